// File: rtl/l1_arbiter_if.sv
// Cache-side and MMU-side signals of the L1 line-fill arbiter.
// master = arbiter view; slave = caches plus l1mmu view.
interface l1_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              ic_req_read;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_read_data;

    logic              dc_req_read;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_done;
    logic [LINE_W-1:0] dc_read_data;

    logic              mmu_req_read;
    logic              mmu_req_write;
    logic [ADDR_W-1:0] mmu_req_addr;
    logic [LINE_W-1:0] mmu_write_data;
    logic              mmu_done;
    logic [LINE_W-1:0] mmu_read_data;

    modport master (
        input  ic_req_read, ic_req_addr,
        output ic_done, ic_read_data,
        input  dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
        output dc_done, dc_read_data,
        output mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
        input  mmu_done, mmu_read_data
    );

    modport slave (
        output ic_req_read, ic_req_addr,
        input  ic_done, ic_read_data,
        output dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
        input  dc_done, dc_read_data,
        input  mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
        output mmu_done, mmu_read_data
    );
endinterface

// File: rtl/l1_arbiter.sv
// Round-robin arbiter of iCache/dCache line requests onto the single l1mmu port.
// Latency: grant +1 cycle to MMU request, mmu_done +1 to cache done; requests wait (level-held) while busy.
module l1_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input logic          sys_clk,
    input logic          rst_n,
    l1_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 0 = iCache, 1 = dCache
    req_t              req_q, req_d;
    logic [LINE_W-1:0] resp_q, resp_d;
    logic              dc_any;
    logic              grant_i;
    logic              grant_d;
    logic              busy;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_q        <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        resp_d       = resp_q;
        dc_any       = bus.dc_req_read | bus.dc_req_write;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                grant_i = bus.ic_req_read & (~dc_any | last_grant_q);
                grant_d = dc_any & (~bus.ic_req_read | ~last_grant_q);
                if (grant_i) begin
                    req_d.rd     = 1'b1;
                    req_d.wr     = 1'b0;
                    req_d.addr   = bus.ic_req_addr;
                    last_grant_d = 1'b0;
                    state_d      = BUSY_I;
                end else if (grant_d) begin
                    req_d.rd     = ~bus.dc_req_write;
                    req_d.wr     = bus.dc_req_write;
                    req_d.addr   = bus.dc_req_addr;
                    req_d.wdata  = bus.dc_write_data;
                    last_grant_d = 1'b1;
                    state_d      = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mmu_done) begin
                    if (req_q.rd) begin
                        resp_d = bus.mmu_read_data;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    assign bus.mmu_req_read   = busy & req_q.rd;
    assign bus.mmu_req_write  = busy & req_q.wr;
    assign bus.mmu_req_addr   = req_q.addr;
    assign bus.mmu_write_data = req_q.wdata;

    // last_grant is updated at grant time, so in RESP it names the owner.
    assign bus.ic_done      = (state_q == RESP) & ~last_grant_q;
    assign bus.dc_done      = (state_q == RESP) &  last_grant_q;
    assign bus.ic_read_data = resp_q;
    assign bus.dc_read_data = resp_q;
endmodule

// File: tb/tb_l1_arbiter.sv
// Directed bench for l1_arbiter: reset, single read, tie order, round-robin, write-back, stray mmu_done.
module tb_l1_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic sys_clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    l1_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    l1_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.mmu_req_read | bus.mmu_req_write;
        end
        check_val({tag, "_grant"}, LINE_W'(seen), LINE_W'(1'b1));
    endtask

    // Entered in the first cycle the MMU request is visible; mmu_done is raised lat cycles later.
    task automatic serve(input string tag, input int lat, input logic [LINE_W-1:0] rdata,
                         input bit exp_wr, input logic [ADDR_W-1:0] exp_addr,
                         input logic [LINE_W-1:0] exp_wdata, input bit exp_d,
                         input logic [LINE_W-1:0] exp_resp);
        int span;
        span = 1;
        check_val({tag, "_addr0"}, LINE_W'(bus.mmu_req_addr), LINE_W'(exp_addr));
        for (int i = 0; i < lat; i++) begin
            step();
            if (bus.mmu_req_read | bus.mmu_req_write) span++;
        end
        check_val({tag, "_addr"}, LINE_W'(bus.mmu_req_addr), LINE_W'(exp_addr));
        check_val({tag, "_rd"}, LINE_W'(bus.mmu_req_read), LINE_W'(!exp_wr));
        check_val({tag, "_wr"}, LINE_W'(bus.mmu_req_write), LINE_W'(exp_wr));
        if (exp_wr) check_val({tag, "_wdata"}, bus.mmu_write_data, exp_wdata);
        bus.mmu_done      = 1'b1;
        bus.mmu_read_data = rdata;
        step();
        bus.mmu_done      = 1'b0;
        bus.mmu_read_data = '0;
        check_val({tag, "_span"}, LINE_W'(span), LINE_W'(lat + 1));
        check_val({tag, "_req_off"}, LINE_W'(bus.mmu_req_read | bus.mmu_req_write), '0);
        check_val({tag, "_ic_done"}, LINE_W'(bus.ic_done), LINE_W'(!exp_d));
        check_val({tag, "_dc_done"}, LINE_W'(bus.dc_done), LINE_W'(exp_d));
        check_val({tag, "_data"}, exp_d ? bus.dc_read_data : bus.ic_read_data, exp_resp);
    endtask

    initial begin
        logic [LINE_W-1:0] line_a5;
        logic [LINE_W-1:0] rr_data;
        logic [LINE_W-1:0] last_resp;
        logic [LINE_W-1:0] wb_data;
        logic [31:0]       w;

        line_a5 = {32{8'hA5}};
        wb_data = {8{32'h1234_5678}};

        bus.ic_req_read   = 1'b0;
        bus.ic_req_addr   = '0;
        bus.dc_req_read   = 1'b0;
        bus.dc_req_write  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_write_data = '0;
        bus.mmu_done      = 1'b0;
        bus.mmu_read_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_ic_done", LINE_W'(bus.ic_done), '0);
        check_val("rst_dc_done", LINE_W'(bus.dc_done), '0);
        check_val("rst_mmu_rd", LINE_W'(bus.mmu_req_read), '0);
        check_val("rst_mmu_wr", LINE_W'(bus.mmu_req_write), '0);
        check_val("rst_mmu_addr", LINE_W'(bus.mmu_req_addr), '0);
        check_val("rst_mmu_wdata", bus.mmu_write_data, '0);
        check_val("rst_ic_data", bus.ic_read_data, '0);
        step();
        step();
        rst_n = 1'b1;

        // Single iCache read, MMU answers 4 cycles after seeing the request.
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h0000_0040;
        step();
        check_val("single_lat", LINE_W'(bus.mmu_req_read), LINE_W'(1'b1));
        serve("single", 4, line_a5, 1'b0, 32'h40, '0, 1'b0, line_a5);
        bus.ic_req_read = 1'b0;
        step();
        check_val("single_pulse", LINE_W'(bus.ic_done | bus.dc_done), '0);

        // Reset while BUSY_I, then a late mmu_done.
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h0000_0080;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        check_val("midrst_mmu_rd", LINE_W'(bus.mmu_req_read), '0);
        check_val("midrst_mmu_addr", LINE_W'(bus.mmu_req_addr), '0);
        check_val("midrst_ic_data", bus.ic_read_data, '0);
        check_val("midrst_ic_done", LINE_W'(bus.ic_done), '0);
        bus.ic_req_read = 1'b0;
        step();
        rst_n = 1'b1;
        bus.mmu_done = 1'b1;
        step();
        bus.mmu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("late_done_quiet", LINE_W'(bus.ic_done | bus.dc_done), '0);
            step();
        end

        // Simultaneous requests right after reset: I first, then D.
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h0000_0100;
        bus.dc_req_read = 1'b1;
        bus.dc_req_addr = 32'h0000_0200;
        step();
        serve("sim_i", 1, {8{32'h1111_0001}}, 1'b0, 32'h100, '0, 1'b0, {8{32'h1111_0001}});
        bus.ic_req_read = 1'b0;
        wait_req("sim_d");
        serve("sim_d", 2, {8{32'h2222_0002}}, 1'b0, 32'h200, '0, 1'b1, {8{32'h2222_0002}});
        bus.dc_req_read = 1'b0;
        step();

        // Both caches held continuously: grants alternate starting with I.
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h0000_1000;
        bus.dc_req_read = 1'b1;
        bus.dc_req_addr = 32'h0000_2000;
        rr_data = '0;
        for (int g = 0; g < 6; g++) begin
            if (g > 0) begin
                step();
                check_val("rr_pulse", LINE_W'(bus.ic_done | bus.dc_done), '0);
            end
            wait_req("rr");
            w = 32'hC0DE_0000 | 32'(g);
            rr_data = {8{w}};
            serve("rr", 1, rr_data, 1'b0, (g % 2 == 1) ? 32'h2000 : 32'h1000, '0,
                  (g % 2 == 1), rr_data);
        end
        last_resp = rr_data;
        bus.ic_req_read = 1'b0;
        bus.dc_req_read = 1'b0;
        step();
        check_val("rr_end_pulse", LINE_W'(bus.ic_done | bus.dc_done), '0);

        // dCache write-back with read also high; inputs change during BUSY.
        bus.dc_req_write  = 1'b1;
        bus.dc_req_read   = 1'b1;
        bus.dc_req_addr   = 32'h3000_0000;
        bus.dc_write_data = wb_data;
        wait_req("wb");
        bus.dc_req_addr   = 32'h4000_0000;
        bus.dc_write_data = '1;
        serve("wb", 3, {8{32'hDEAD_BEEF}}, 1'b1, 32'h3000_0000, wb_data, 1'b1, last_resp);
        bus.dc_req_write = 1'b0;
        bus.dc_req_read  = 1'b0;
        step();
        check_val("wb_pulse", LINE_W'(bus.dc_done), '0);

        // Stray mmu_done while IDLE.
        bus.mmu_done      = 1'b1;
        bus.mmu_read_data = {8{32'hBAD0_BAD0}};
        step();
        bus.mmu_done      = 1'b0;
        bus.mmu_read_data = '0;
        check_val("spur_done", LINE_W'(bus.ic_done | bus.dc_done), '0);
        check_val("spur_req", LINE_W'(bus.mmu_req_read | bus.mmu_req_write), '0);
        step();
        check_val("spur_done2", LINE_W'(bus.ic_done | bus.dc_done), '0);
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h0000_0500;
        step();
        check_val("spur_next_lat", LINE_W'(bus.mmu_req_read), LINE_W'(1'b1));
        serve("spur_next", 2, {8{32'h5555_AAAA}}, 1'b0, 32'h500, '0, 1'b0, {8{32'h5555_AAAA}});
        bus.ic_req_read = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/l1_arbiter.md
# l1_arbiter

Registered two-port arbiter between the L1 instruction cache and the L1 data cache on one side and the single `l1mmu` line-fill/write-back port on the other. It replaces the combinational iCache-priority request mux. Each request is latched on grant, the MMU request is held stable until `mmu_done`, and the response is returned as a registered one-cycle done pulse with a 256-bit line. Ties are resolved round-robin, so neither cache can starve the other.

## Interface
- `LINE_W`, 256: cache line width in bits.
- `ADDR_W`, 32: byte address width.

Ports:
- `sys_clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ic_req_read` in 1: iCache line-read request (level, held until `ic_done`).
- `ic_req_addr` in ADDR_W: iCache request address.
- `ic_done` out 1: one-cycle completion pulse to iCache.
- `ic_read_data` out LINE_W: line returned to iCache, valid while `ic_done`=1.
- `dc_req_read` in 1: dCache line-read request (level).
- `dc_req_write` in 1: dCache line write-back request (level).
- `dc_req_addr` in ADDR_W: dCache request address.
- `dc_write_data` in LINE_W: dCache write-back line.
- `dc_done` out 1: one-cycle completion pulse to dCache.
- `dc_read_data` out LINE_W: line returned to dCache, valid while `dc_done`=1 on a read.
- `mmu_req_read` out 1: read request to `l1mmu`.
- `mmu_req_write` out 1: write request to `l1mmu`.
- `mmu_req_addr` out ADDR_W: latched request address.
- `mmu_write_data` out LINE_W: latched write line.
- `mmu_done` in 1: `l1mmu` completion, one cycle.
- `mmu_read_data` in LINE_W: `l1mmu` read line, valid with `mmu_done`.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Register `last_grant` holds 0=I or 1=D.
- **IDLE, request sampling:** a dCache request is `dc_req_read|dc_req_write`.
- **IDLE, only one requester active:** grant it.
- **IDLE, both active:** grant the one not equal to `last_grant`.
- **IDLE, on grant:**
  - Latch addr, write data and op into the request register.
  - Update `last_grant`.
  - Go to BUSY_I or BUSY_D.
- **dCache op select:** if `dc_req_write` and `dc_req_read` are both high, the write is taken and the read is ignored for that grant.
- **BUSY_x:**
  - `mmu_req_read`/`mmu_req_write`, `mmu_req_addr` and `mmu_write_data` are driven from registers and stay constant.
  - Requester inputs are ignored.
  - On `mmu_done`: capture `mmu_read_data` into the response buffer (reads only) and go to RESP.
- **RESP:**
  - Pulse exactly one of `ic_done`/`dc_done`.
  - `ic_read_data`/`dc_read_data` are driven from the response buffer.
  - Go to IDLE.
- **Requester contract:** the requester drops or replaces its request on the edge where it samples done. A request still high in IDLE counts as a new request.
- **`mmu_done` outside BUSY_x:** ignored; no state change, no pulse.
- **Write completion:** on a write, the response buffer keeps its previous value and `dc_done` still pulses.
- **Requests arriving during BUSY/RESP:** wait. They are not lost as long as they are held.

## Timing
- **Reset (async assert):**
  - State=IDLE, `last_grant`=D, so the first tie goes to I.
  - All `*_done`, `mmu_req_read` and `mmu_req_write` = 0.
  - `mmu_req_addr`, `mmu_write_data`, response buffer and `*_read_data` = 0.
- **Reset mid-transaction:** the transaction is dropped, outputs go to reset values immediately, and no done is issued afterwards.
- **Latency:**
  - Request high in cycle 0 → MMU request high from cycle 1.
  - `mmu_done` in cycle N → requester done in cycle N+1.
  - Minimum round trip is 3 cycles (`mmu_done` in cycle 1).
  - The next grant is decided in IDLE at cycle N+2.
- **MMU request span:** asserted from the grant cycle+1 through the cycle `mmu_done` is high, inclusive; low in RESP.
- **Back-to-back:**
  - Sustained traffic from both caches alternates I, D, I, D.
  - A single requester gets one grant every 3+L cycles, where L is the MMU latency.
- **Read-data mux:** `*_read_data` may be the shared response buffer, but only the matching done qualifies it.

## Test plan
- **Reset mid-BUSY_I:**
  - Stimulus: `rst_n` low while in BUSY_I, then a late `mmu_done`.
  - Required: all outputs 0 within the same cycle; the late `mmu_done` produces no done pulse.
- **Single iCache read:**
  - Stimulus: `ic_req_read`=1, addr 0x0000_0040; `l1mmu` model returns 0xA5…A5 after 4 cycles.
  - Required: `mmu_req_read`=1 with addr 0x40 for 5 cycles, then `ic_done`=1 for exactly one cycle with data 0xA5…A5; `dc_done` stays 0.
- **Simultaneous requests after reset:**
  - Stimulus: I read at 0x100 and D read at 0x200 raised in the same cycle and held.
  - Required: I is served first, then D; `mmu_req_addr` shows 0x100 then 0x200.
- **Round-robin fairness:**
  - Stimulus: both caches hold requests continuously for 6 grants.
  - Required: grant order I, D, I, D, I, D; no two consecutive grants to the same requester.
- **dCache write-back:**
  - Stimulus: `dc_req_write`=1 with `dc_req_read`=1, addr 0x3000_0000, data 0x1234…; `dc_req_addr`/`dc_write_data` changed during BUSY.
  - Required: `mmu_req_write`=1, `mmu_req_read`=0, and addr/data are unchanged from the values latched at grant; `dc_done` pulses; `dc_read_data` keeps its prior value.
- **Spurious `mmu_done` in IDLE:**
  - Stimulus: `mmu_done`=1 while IDLE with no request pending.
  - Required: state stays IDLE, no done pulse; a following I request completes normally.
